// File: rtl/alu_wb_stage.sv
// ALU execute/writeback stage with one-shot issue and registered writeback.
// Optional iterative shift-add multiplier for OP=111 enabled by ALU_WB_MUL_EN.
module alu_wb_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [2:0]  OP,
    input  logic [15:0] ABUS,
    input  logic [15:0] BBUS,
    input  logic [2:0]  DEST,
    output logic [15:0] RIN,
    output logic [2:0]  DSEL,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  FLAGS
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  op_q;
    logic [2:0]  dest_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        mul_done;
    logic [15:0] res;
    logic        c_f;
    logic        v_f;
    logic [16:0] sum;
    logic [2:0]  wsel;

`ifdef ALU_WB_MUL_EN
    logic [15:0] acc_q;
    logic [15:0] mcand_q;
    logic [15:0] mplier_q;
    logic [4:0]  cnt_q;

    assign mul_done = (cnt_q == 5'd16);
    assign wsel     = dest_q;
`else
    assign mul_done = 1'b0;
    assign wsel     = (op_q == 3'b111) ? 3'd0 : dest_q;
`endif

    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (START) begin
`ifdef ALU_WB_MUL_EN
                    state_nx = (OP == 3'b111) ? MUL : EXEC;
`else
                    state_nx = EXEC;
`endif
                end
            end
            EXEC: state_nx = WB;
            MUL:  if (mul_done) state_nx = WB;
            WB:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        res = 16'd0;
        c_f = 1'b0;
        v_f = 1'b0;
        sum = 17'd0;
        unique case (op_q)
            3'b000: begin
                sum = {1'b0, a_q} + {1'b0, b_q};
                res = sum[15:0];
                c_f = sum[16];
                v_f = (a_q[15] == b_q[15]) && (res[15] != a_q[15]);
            end
            3'b001: begin
                res = a_q - b_q;
                c_f = (a_q < b_q);
                v_f = (a_q[15] != b_q[15]) && (res[15] != a_q[15]);
            end
            3'b010: res = a_q & b_q;
            3'b011: res = a_q | b_q;
            3'b100: res = a_q ^ b_q;
            3'b101: begin
                res = {a_q[14:0], 1'b0};
                c_f = a_q[15];
            end
            3'b110: begin
                res = {1'b0, a_q[15:1]};
                c_f = a_q[0];
            end
            3'b111: begin
`ifdef ALU_WB_MUL_EN
                res = acc_q;
`else
                res = 16'd0;
`endif
            end
            default: res = 16'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            op_q   <= 3'd0;
            dest_q <= 3'd0;
            a_q    <= 16'd0;
            b_q    <= 16'd0;
            RIN    <= 16'd0;
            DSEL   <= 3'd0;
            DONE   <= 1'b0;
            FLAGS  <= 4'd0;
`ifdef ALU_WB_MUL_EN
            acc_q    <= 16'd0;
            mcand_q  <= 16'd0;
            mplier_q <= 16'd0;
            cnt_q    <= 5'd0;
`endif
        end else begin
            DONE <= 1'b0;
            DSEL <= 3'd0;
            if (state == IDLE && START) begin
                op_q   <= OP;
                dest_q <= DEST;
                a_q    <= ABUS;
                b_q    <= BBUS;
`ifdef ALU_WB_MUL_EN
                acc_q    <= 16'd0;
                mcand_q  <= ABUS;
                mplier_q <= BBUS;
                cnt_q    <= 5'd0;
`endif
            end
`ifdef ALU_WB_MUL_EN
            // One multiplier bit per cycle; the 17th MUL cycle hands off to WB.
            if (state == MUL && !mul_done) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= {mcand_q[14:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[15:1]};
                cnt_q    <= cnt_q + 5'd1;
            end
`endif
            if (state_nx == WB) begin
                RIN   <= res;
                DSEL  <= wsel;
                DONE  <= 1'b1;
                FLAGS <= {res == 16'd0, res[15], c_f, v_f};
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: timeline model checked every cycle plus literal vectors.
// Define ALU_WB_MUL_EN for both bench and RTL to exercise the multiplier build.
module tb_alu_wb_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [2:0]  OP = 3'd0;
    logic [15:0] ABUS = 16'd0;
    logic [15:0] BBUS = 16'd0;
    logic [2:0]  DEST = 3'd0;
    logic [15:0] RIN;
    logic [2:0]  DSEL;
    logic        BUSY;
    logic        DONE;
    logic [3:0]  FLAGS;

    int checks = 0;
    int errors = 0;

    alu_wb_stage dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP),
        .ABUS(ABUS), .BBUS(BBUS), .DEST(DEST),
        .RIN(RIN), .DSEL(DSEL), .BUSY(BUSY),
        .DONE(DONE), .FLAGS(FLAGS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome of one operation, straight from the ISA rules.
    function automatic void calc(input logic [2:0] op,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic [2:0] d,
                                 output logic [15:0] r,
                                 output logic [3:0] f,
                                 output logic [2:0] ds,
                                 output int lat);
        int sa, sb, s;
        longint p;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        ds = d;
        lat = 1;
        r = 16'd0;
        sa = a[15] ? int'(a) - 65536 : int'(a);
        sb = b[15] ? int'(b) - 65536 : int'(b);
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                r = s[15:0];
                c = (s > 65535);
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                s = int'(a) - int'(b);
                r = s[15:0];
                c = (a < b);
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                s = int'(a) * 2;
                r = s[15:0];
                c = a[15];
            end
            3'd6: begin
                s = int'(a) / 2;
                r = s[15:0];
                c = a[0];
            end
            default: begin
`ifdef ALU_WB_MUL_EN
                p = longint'(a) * longint'(b);
                r = p[15:0];
                lat = 17;
`else
                p = 0;
                r = p[15:0];
                ds = 3'd0;
`endif
            end
        endcase
        f = {r == 16'd0, r[15], c, v};
    endfunction

    int          cyc = 0;
    int          wb_cyc = 0;
    bit          act = 0;
    bit          armed = 0;
    bit          free;
    logic [15:0] m_rin = 0, p_rin;
    logic [2:0]  m_dsel = 0, p_dsel;
    logic [3:0]  m_flags = 0, p_flags;
    logic        m_done = 0;
    int          p_lat;

    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            armed = 1;
            act = 0;
            m_rin = 0;
            m_dsel = 0;
            m_done = 0;
            m_flags = 0;
        end else begin
            free = !act;
            m_done = 0;
            m_dsel = 0;
            if (act && cyc == wb_cyc) begin
                m_rin = p_rin;
                m_dsel = p_dsel;
                m_done = 1;
                m_flags = p_flags;
            end
            if (act && cyc == wb_cyc + 1) act = 0;
            if (free && START) begin
                calc(OP, ABUS, BBUS, DEST, p_rin, p_flags, p_dsel, p_lat);
                act = 1;
                wb_cyc = cyc + p_lat;
            end
        end
        #1;
        if (armed) begin
            check("model_rin", 32'(RIN), 32'(m_rin));
            check("model_dsel", 32'(DSEL), 32'(m_dsel));
            check("model_done", 32'(DONE), 32'(m_done));
            check("model_busy", 32'(BUSY), 32'(act));
            check("model_flags", 32'(FLAGS), 32'(m_flags));
        end
    end

    task automatic issue(input logic [2:0] op,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic [2:0] d,
                         output int k,
                         output logic [15:0] r,
                         output logic [2:0] ds,
                         output logic [3:0] f);
        @(negedge CLK);
        START = 1;
        OP = op;
        ABUS = a;
        BBUS = b;
        DEST = d;
        @(negedge CLK);
        START = 0;
        OP = 3'($urandom);
        ABUS = 16'($urandom);
        BBUS = 16'($urandom);
        DEST = 3'($urandom);
        k = 0;
        while (!DONE && k < 40) begin
            @(negedge CLK);
            k++;
        end
        r = RIN;
        ds = DSEL;
        f = FLAGS;
        @(negedge CLK);
    endtask

    int          k, npulse, last, exp_k;
    logic [15:0] r;
    logic [2:0]  ds;
    logic [3:0]  f;

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_rin", 32'(RIN), 0);
        check("rst_dsel", 32'(DSEL), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_flags", 32'(FLAGS), 0);
        RST = 1;

        issue(3'd0, 16'h7FFF, 16'h0001, 3'd3, k, r, ds, f);
        check("add_lat", k, 1);
        check("add_rin", 32'(r), 32'h8000);
        check("add_dsel", 32'(ds), 3);
        check("add_flags", 32'(f), 32'b0101);
        check("add_done_drop", 32'(DONE), 0);

        issue(3'd1, 16'h0005, 16'h0005, 3'd1, k, r, ds, f);
        check("sub0_rin", 32'(r), 0);
        check("sub0_flags", 32'(f), 32'b1000);

        issue(3'd1, 16'h0001, 16'h0002, 3'd1, k, r, ds, f);
        check("subb_rin", 32'(r), 32'hFFFF);
        check("subb_flags", 32'(f), 32'b0110);

        issue(3'd1, 16'h8000, 16'h0001, 3'd2, k, r, ds, f);
        check("subv_rin", 32'(r), 32'h7FFF);
        check("subv_flags", 32'(f), 32'b0001);

        issue(3'd0, 16'hFFFF, 16'h0001, 3'd2, k, r, ds, f);
        check("addc_flags", 32'(f), 32'b1010);

        issue(3'd2, 16'hF0F0, 16'h0FF0, 3'd5, k, r, ds, f);
        check("and_rin", 32'(r), 32'h00F0);
        issue(3'd3, 16'h8000, 16'h0001, 3'd6, k, r, ds, f);
        check("or_rin", 32'(r), 32'h8001);
        check("or_flags", 32'(f), 32'b0100);
        issue(3'd4, 16'hAAAA, 16'hAAAA, 3'd6, k, r, ds, f);
        check("xor_flags", 32'(f), 32'b1000);
        issue(3'd6, 16'h8003, 16'h0000, 3'd4, k, r, ds, f);
        check("shr_rin", 32'(r), 32'h4001);
        check("shr_flags", 32'(f), 32'b0010);

        issue(3'd7, 16'h0123, 16'h0045, 3'd7, k, r, ds, f);
`ifdef ALU_WB_MUL_EN
        check("mul_lat", k, 17);
        check("mul_rin", 32'(r), 32'h4E6F);
        check("mul_dsel", 32'(ds), 7);
        check("mul_flags", 32'(f), 0);
`else
        check("mul_off_lat", k, 1);
        check("mul_off_rin", 32'(r), 0);
        check("mul_off_dsel", 32'(ds), 0);
        check("mul_off_flags", 32'(f), 32'b1000);
`endif

        issue(3'd5, 16'h8001, 16'h0000, 3'd0, k, r, ds, f);
        check("shl_lat", k, 1);
        check("shl_dsel", 32'(ds), 0);
        check("shl_rin", 32'(r), 32'h0002);
        check("shl_flags", 32'(f), 32'b0010);

        @(negedge CLK);
        START = 1;
`ifdef ALU_WB_MUL_EN
        OP = 3'd7;
`else
        OP = 3'd0;
`endif
        ABUS = 16'h0123;
        BBUS = 16'h0045;
        DEST = 3'd7;
        @(negedge CLK);
        START = 0;
`ifdef ALU_WB_MUL_EN
        repeat (4) @(negedge CLK);
`endif
        RST = 0;
        START = 1;
        @(negedge CLK);
        check("abort_rin", 32'(RIN), 0);
        check("abort_dsel", 32'(DSEL), 0);
        check("abort_done", 32'(DONE), 0);
        check("abort_busy", 32'(BUSY), 0);
        check("abort_flags", 32'(FLAGS), 0);
        RST = 1;
        START = 0;
        @(negedge CLK);
        check("rst_start_ignored", 32'(BUSY), 0);

        issue(3'd0, 16'h0002, 16'h0003, 3'd4, k, r, ds, f);
        check("post_rst_lat", k, 1);
        check("post_rst_rin", 32'(r), 5);
        check("post_rst_dsel", 32'(ds), 4);

        @(negedge CLK);
        START = 1;
        OP = 3'd0;
        ABUS = 16'h0001;
        BBUS = 16'h0001;
        DEST = 3'd2;
        npulse = 0;
        last = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            if (DONE) begin
                npulse++;
                exp_k = (npulse == 1) ? 2 : last + 3;
                check("hold_spacing", i, exp_k);
                last = i;
            end
        end
        START = 0;
        check("hold_pulses", npulse, 4);
        check("hold_rin", 32'(RIN), 2);
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
